// File: rtl/spi_main.sv
// SPI controller: frames a 2-bit key-size code plus a 128/192/256-bit payload on sdi,
// captures a 128-bit response from sdo, and ends every frame with one sclk pulse while cs is high.
`default_nettype none

module spi_main #(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [0:255] payload,
  output logic [0:127] rx_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         cs,
  output logic         sclk,
  output logic         sdi,
  input  logic         sdo
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_main: CLK_DIV must be at least 2");
  end

  localparam int              DIV_W    = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_HIGH    = 3'd2;
  localparam logic [2:0] S_LOW     = 3'd3;
  localparam logic [2:0] S_FLUSH_H = 3'd4;
  localparam logic [2:0] S_FLUSH_L = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [8:0]       bit_q, bit_d;
  logic [1:0]       mode_q, mode_d;
  logic [256:0]     tx_q, tx_d;
  logic [0:127]     rx_q, rx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             sdi_q, sdi_d;

  logic [8:0] n_bits;
  logic [8:0] bit_inc;

  always_comb begin
    case (mode_q)
      2'b00:   n_bits = 9'd130;
      2'b01:   n_bits = 9'd194;
      default: n_bits = 9'd258;
    endcase
  end

  assign bit_inc = bit_q + 9'd1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    mode_d  = mode_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    sdi_d   = sdi_q;

    if (state_q == S_IDLE) begin
      div_d = '0;
      if (start) begin
        if (mode == 2'b11) begin
          err_d = 1'b1;
        end else begin
          mode_d  = mode;
          sdi_d   = mode[1];
          tx_d    = {mode[0], payload};
          rx_d    = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          state_d = S_SETUP;
        end
      end
    end else if (div_q != DIV_LAST) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      case (state_q)
        S_SETUP: begin
          state_d = S_HIGH;
          sclk_d  = 1'b1;
        end
        S_HIGH: begin
          state_d = S_LOW;
          sclk_d  = 1'b0;
          bit_d   = bit_inc;
          if (bit_q < 9'd128) rx_d[bit_q[6:0]] = sdo;
          // cs releases on the last falling edge so it never moves together with a rising sclk
          if (bit_inc == n_bits) begin
            sdi_d = 1'b0;
            cs_d  = 1'b1;
          end else begin
            sdi_d = tx_q[256];
            tx_d  = {tx_q[255:0], 1'b0};
          end
        end
        S_LOW: begin
          state_d = (bit_q == n_bits) ? S_FLUSH_H : S_HIGH;
          sclk_d  = 1'b1;
        end
        S_FLUSH_H: begin
          state_d = S_FLUSH_L;
          sclk_d  = 1'b0;
        end
        S_FLUSH_L: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      mode_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      sdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      mode_q  <= mode_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      sdi_q   <= sdi_d;
    end
  end

  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cs      = cs_q;
  assign sclk    = sclk_q;
  assign sdi     = sdi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_main.sv
// Bench for spi_main: a CLK_DIV=4 and a CLK_DIV=2 instance share one subordinate model.
`default_nettype none

module tb_spi_main;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [0:255] payload = '0;
  logic         sdo = 1'b0;
  logic         start4, start2;

  logic [0:127] rx4, rx2;
  logic busy4, done4, err4, cs4, sclk4, sdi4;
  logic busy2, done2, err2, cs2, sclk2, sdi2;

  assign start4 = start & ~sel;
  assign start2 = start & sel;

  spi_main #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .payload(payload),
    .rx_data(rx4), .busy(busy4), .done(done4), .err(err4), .cs(cs4),
    .sclk(sclk4), .sdi(sdi4), .sdo(sdo)
  );

  spi_main #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .payload(payload),
    .rx_data(rx2), .busy(busy2), .done(done2), .err(err2), .cs(cs2),
    .sclk(sclk2), .sdi(sdi2), .sdo(sdo)
  );

  logic [0:127] rx_m;
  logic busy_m, done_m, err_m, cs_m, sclk_m, sdi_m;
  assign rx_m   = sel ? rx2   : rx4;
  assign busy_m = sel ? busy2 : busy4;
  assign done_m = sel ? done2 : done4;
  assign err_m  = sel ? err2  : err4;
  assign cs_m   = sel ? cs2   : cs4;
  assign sclk_m = sel ? sclk2 : sclk4;
  assign sdi_m  = sel ? sdi2  : sdi4;

  int pass_cnt = 0;
  int total_cnt = 0;

  // subordinate model and waveform monitor, sampled on the clk edge opposite the DUT's
  logic         p_sclk = 1'b0, p_cs = 1'b1, p_sdi = 1'b0;
  logic [0:127] resp_m = '0;
  logic         rcv [0:257];
  int rcv_cnt = 0, fall_lo = 0, fall_hi = 0, flush_cnt = 0;
  int edge_bad = 0, phase_bad = 0, done_cnt = 0, err_cnt = 0;
  int run = 0, cur_div = 4;

  always @(negedge clk) begin
    if (sclk_m && !p_sclk) begin
      if (sdi_m != p_sdi || cs_m != p_cs) edge_bad++;
      if (!cs_m) begin
        if (rcv_cnt < 258) rcv[rcv_cnt] = sdi_m;
        sdo = (rcv_cnt < 128) ? resp_m[7'(rcv_cnt)] : 1'b1;
        rcv_cnt++;
      end else begin
        flush_cnt++;
      end
    end else if (!sclk_m && p_sclk) begin
      if (!p_cs) fall_lo++;
      else fall_hi++;
    end else if (sdi_m != p_sdi && !p_cs && rst_n) begin
      edge_bad++;
    end
    if (sclk_m != p_sclk) begin
      if (busy_m && run != cur_div) phase_bad++;
      run = 1;
    end else if (!cs_m && p_cs) begin
      run = 1;
    end else begin
      run++;
    end
    if (done_m) done_cnt++;
    if (err_m) err_cnt++;
    p_sclk = sclk_m;
    p_cs   = cs_m;
    p_sdi  = sdi_m;
  end

  typedef struct {
    logic [1:0]   mode;
    logic [0:255] payload;
    logic [0:127] resp;
    bit           div2;
    int           exp_n;
    int           exp_cyc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [0:255] p, input logic [0:127] r,
                        input bit d2);
    rcv_cnt = 0; fall_lo = 0; fall_hi = 0; flush_cnt = 0;
    edge_bad = 0; phase_bad = 0; err_cnt = 0;
    sel = d2;
    cur_div = d2 ? 2 : 4;
    resp_m = r;
    mode = m;
    payload = p;
    start = 1'b1;
  endtask

  // returns the cycle (cycle 0 = start-sampling edge) in which done is seen high
  task automatic wait_done(input bit inject, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        mode = ~mode;
        payload = ~payload;
        chk("cs_low_cycle1", cs_m, 1'b0);
        chk("busy_cycle1", busy_m, 1'b1);
      end
      if (inject && cyc == 200) begin
        start = 1'b1;
        mode = 2'b10;
        payload = ~payload;
      end
      if (inject && cyc == 201) start = 1'b0;
      if (done_m) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
  endtask

  task automatic check_frame(input logic [1:0] m, input logic [0:255] p,
                             input logic [0:127] r, input int exp_n, input int exp_cyc,
                             input int cyc);
    int bad;
    logic e;
    bad = -1;
    for (int i = 0; i < exp_n; i++) begin
      e = (i == 0) ? m[1] : (i == 1) ? m[0] : p[i-2];
      if (i < 258 && rcv[i] !== e && bad < 0) bad = i;
    end
    chk("done_cycle", cyc, exp_cyc);
    chk("falls_cs_low", fall_lo, exp_n);
    chk("bits_received", rcv_cnt, exp_n);
    chk("sdi_bits_first_bad", bad, -1);
    chk("rx_data", rx_m, r);
    chk("flush_rise_cs_high", flush_cnt, 1);
    chk("flush_fall_cs_high", fall_hi, 1);
    chk("edge_violations", edge_bad, 0);
    chk("phase_len_violations", phase_bad, 0);
    chk("no_err", err_cnt, 0);
  endtask

  initial begin
    int cyc, d0, viol;
    logic [0:255] pa;
    logic [0:127] ra;

    pa = {128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h0};
    ra = 128'hDEADBEEF_01234567_89ABCDEF_76543210;
    vecs[0] = '{2'b00, pa, ra, 1'b0, 130, 1053};
    vecs[1] = '{2'b01, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 1'b0, 194, 1565};
    vecs[2] = '{2'b10, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 1'b0, 258, 2077};
    vecs[3] = '{2'b10, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 1'b1, 258, 1039};
    vecs[4] = '{2'b00, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}, 1'b1, 130, 527};

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs", cs4, 1'b1);
    chk("rst_sclk", sclk4, 1'b0);
    chk("rst_sdi", sdi4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_err", err4, 1'b0);
    chk("rst_rx", rx4, 128'h0);
    chk("rst_cs_div2", cs2, 1'b1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) begin
      launch(vecs[v].mode, vecs[v].payload, vecs[v].resp, vecs[v].div2);
      wait_done(1'b0, cyc);
      check_frame(vecs[v].mode, vecs[v].payload, vecs[v].resp, vecs[v].exp_n, vecs[v].exp_cyc, cyc);
      tick();
      chk("done_one_cycle", done_m, 1'b0);
      chk("busy_after_done", busy_m, 1'b0);
      repeat (3) tick();
    end

    // illegal mode: err pulse only, previous rx_data held
    sel = 1'b0;
    d0 = err_cnt;
    mode = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", err4, 1'b1);
    chk("err_busy", busy4, 1'b0);
    chk("err_cs", cs4, 1'b1);
    chk("err_sclk", sclk4, 1'b0);
    tick();
    chk("err_one_cycle", err4, 1'b0);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy4 || !cs4 || sclk4) viol++;
    end
    chk("err_idle_violations", viol, 0);
    chk("err_pulse_count", err_cnt - d0, 1);
    chk("rx_hold", rx4, vecs[2].resp);

    // start while busy is ignored; start in the done cycle begins the next frame
    launch(2'b00, pa, ra, 1'b0);
    wait_done(1'b1, cyc);
    check_frame(2'b00, pa, ra, 130, 1053, cyc);
    launch(vecs[1].mode, vecs[1].payload, vecs[1].resp, 1'b0);
    wait_done(1'b0, cyc);
    check_frame(vecs[1].mode, vecs[1].payload, vecs[1].resp, 194, 1565, cyc);
    repeat (3) tick();

    // asynchronous reset mid-frame
    launch(2'b00, pa, ra, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && rcv_cnt < 60; i++) tick();
    chk("reached_60_bits", rcv_cnt, 60);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs", cs4, 1'b1);
    chk("abort_sclk", sclk4, 1'b0);
    chk("abort_busy", busy4, 1'b0);
    chk("abort_rx", rx4, 128'h0);
    d0 = done_cnt;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (1100) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    launch(2'b00, pa, ra, 1'b0);
    wait_done(1'b0, cyc);
    check_frame(2'b00, pa, ra, 130, 1053, cyc);
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
